gather_rr_arbiter: RTL
======================

// Module: gather_rr_arbiter
// PURPOSE
//  Shares one OUT-wide gather port between IN requesters using a round-robin arbiter.
//  - Each cycle it grants up to OUT active requests, scanning circularly from a rotating pointer.
//  - Granted payloads are compacted into a registered output bundle with a valid/ready handshake.
//  - Sits in front of multi-issue consumers (issue/commit/write-back ports), where the plain
//    gather compaction is fixed-priority and would starve high-index requesters.
// PARAMETERS
//  DATA  32     payload width per requester
//  IN    8      requester count (>=2)
//  OUT   4      output lanes per cycle (1..IN)
//  ACT   `High  polarity of req/gnt/out_valid; inactive level = ~ACT
//  CNTW  32     width of statistics counters (STAT option only)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous reset, active-high
//  req            in   IN         per-requester request; held until granted
//  req_data       in   IN*DATA    payload, packed [IN-1:0][DATA-1:0]
//  gnt            out  IN         combinational grant; payload captured this edge
//  out_valid      out  OUT        registered lane valid, packed from lane 0 upward
//  out_data       out  OUT*DATA   registered compacted payloads
//  out_ready      in   1          consumer accepts the whole bundle
//  stat_gnt_cnt   out  CNTW       total entries granted (GATHER_ARB_STAT_EN only)
//  stat_stall_cnt out  CNTW       cycles with active req but load blocked (GATHER_ARB_STAT_EN only)
// BEHAVIOUR
//  - Reset (synchronous, reset=1 at the edge):
//      out_valid all inactive; out_data = 0; ptr = 0; stat counters = 0.
//      gnt is forced all inactive while reset is high.
//  - load = ~|active(out_valid) | out_ready.
//      Bundle is all-or-nothing: no partial consumption.
//  - load=1:
//      scan i = ptr, ptr+1, ..., wrapping mod IN; take the first min(OUT, #active req) requesters.
//      k-th taken requester -> gnt active, out_data[k] <= req_data[i], out_valid[k] <= ACT.
//      Lanes k >= taken count: out_valid inactive, out_data = 0.
//  - load=0 (stall): gnt all inactive; out_valid, out_data and ptr hold.
//  - Pointer: if any grant, ptr <= (last granted index + 1) mod IN; otherwise ptr holds.
//      ptr is clog2(IN) bits; wrap from IN-1 to 0 is explicit, valid for non-power-of-2 IN.
//  - Latency: request granted in cycle t -> payload on out_data in cycle t+1.
//      Zero-bubble throughput while out_ready=1.
//  - Fewer than OUT active requests: all are granted in one cycle.
//  - No active requests with load=1: bundle becomes empty (all out_valid inactive).
//  - A requester dropping req without a grant is legal; it is simply not selected.
//  - Fairness: an active requester is granted within ceil(IN/OUT) loading cycles.
//  - Reset mid-operation: the in-flight bundle is discarded.
//      No gnt is issued in the reset cycle; arbitration restarts at ptr = 0.
// CONFIGURATION
//  GATHER_ARB_STAT_EN defined:
//    stat_gnt_cnt += popcount(gnt) each cycle, saturating at all-ones.
//    stat_stall_cnt += 1 when load=0 and any req is active, saturating.
//  Undefined: the stat ports and counters are absent; all other behaviour is identical.
// TESTING  (IN=8, OUT=4, DATA=32, ACT=`High, req_data[i]=i+1 unless stated)
//  1. Hold reset 3 cycles with req=8'hFF:
//     -> gnt=0, out_valid=0, out_data=0; first post-reset grant is 8'h0F (ptr=0).
//  2. req=8'b0010_0011, out_ready=1:
//     -> gnt=8'h23 same cycle; next cycle out_valid=4'b0111, out_data={0,6,2,1}; ptr=6.
//  3. From ptr=6, req=8'hFF, out_ready=1:
//     -> gnt=8'hC3; next cycle out_data={2,1,8,7}; ptr=2.
//     -> following cycle gnt=8'h3C, out_data={6,5,4,3}.
//  4. Bundle valid, out_ready=0 for 3 cycles, req=8'hFF:
//     -> gnt=0, out held stable, ptr unchanged; with STAT stat_stall_cnt=3.
//     -> out_ready=1 resumes at the held ptr.
//  5. Assert reset mid-stream with out_valid=4'hF:
//     -> next cycle out_valid=0, out_data=0, ptr=0, counters=0.
//  6. 1000 cycles of random req, req_data and out_ready (req held until granted):
//     -> bundle order, gnt and ptr match the behavioural model.
//     -> every request is granted within 2 loading cycles; no payload lost or duplicated.

Source files
------------

// File: rtl/gather_rr_arbiter.sv
// gather_rr_arbiter: round-robin gather of up to OUT of IN requesters per cycle
// into a registered, all-or-nothing output bundle with a valid/ready handshake.
// Optional statistics counters are built when GATHER_ARB_STAT_EN is defined.
module gather_rr_arbiter #(
  parameter int unsigned DATA = 32,
  parameter int unsigned IN   = 8,
  parameter int unsigned OUT  = 4,
  parameter logic        ACT  = 1'b1,
  parameter int unsigned CNTW = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN-1:0]             req,
  input  logic [IN-1:0][DATA-1:0]   req_data,
  output logic [IN-1:0]             gnt,
  output logic [OUT-1:0]            out_valid,
  output logic [OUT-1:0][DATA-1:0]  out_data,
  input  logic                      out_ready
`ifdef GATHER_ARB_STAT_EN
  ,
  output logic [CNTW-1:0]           stat_gnt_cnt,
  output logic [CNTW-1:0]           stat_stall_cnt
`endif
);

  localparam int unsigned PW = (IN > 1) ? $clog2(IN) : 1;
  localparam int unsigned KW = $clog2(OUT + 1);

  // Internal state and decisions are kept active-high; ACT is applied at the pins.
  logic [IN-1:0]            req_act;
  logic [IN-1:0]            gnt_int;
  logic [OUT-1:0]           vld_q, vld_d;
  logic [OUT-1:0][DATA-1:0] data_q, data_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [KW-1:0]            taken;
  logic [PW-1:0]            last_idx;
  logic [PW:0]              sum;
  logic [PW-1:0]            idx;
  logic                     load;

  assign req_act = ACT ? req : ~req;

  // A new bundle may be loaded when the current one is empty or being accepted.
  assign load = ~(|vld_q) | out_ready;

  // Circular scan from ptr: grant and compact the first OUT active requesters.
  always_comb begin
    gnt_int  = '0;
    vld_d    = '0;
    data_d   = '0;
    taken    = '0;
    last_idx = '0;
    sum      = '0;
    idx      = '0;
    for (int unsigned j = 0; j < IN; j++) begin
      // ptr < IN and j < IN, so one subtraction always lands back in range.
      sum = {1'b0, ptr_q} + (PW + 1)'(j);
      if (sum >= (PW + 1)'(IN)) begin
        sum = sum - (PW + 1)'(IN);
      end
      idx = sum[PW-1:0];
      if (load && !reset && req_act[idx] && (taken < KW'(OUT))) begin
        gnt_int[idx] = 1'b1;
        for (int unsigned k = 0; k < OUT; k++) begin
          if (KW'(k) == taken) begin
            data_d[k] = req_data[idx];
            vld_d[k]  = 1'b1;
          end
        end
        taken    = taken + 1'b1;
        last_idx = idx;
      end
    end
  end

  // Next pointer: one past the last granted requester, explicit wrap for any IN.
  always_comb begin
    ptr_d = ptr_q;
    if (taken != '0) begin
      ptr_d = (last_idx == PW'(IN - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Bundle and pointer registers; stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      data_q <= '0;
      ptr_q  <= '0;
    end else if (load) begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
    end
  end

  // Pin polarity.
  always_comb begin
    gnt       = ACT ? gnt_int : ~gnt_int;
    out_valid = ACT ? vld_q : ~vld_q;
    out_data  = data_q;
  end

`ifdef GATHER_ARB_STAT_EN
  logic [CNTW-1:0] gnt_cnt_q, stall_cnt_q;
  logic [CNTW:0]   gnt_sum;
  logic            stall_inc;

  assign gnt_sum   = {1'b0, gnt_cnt_q} + (CNTW + 1)'(taken);
  assign stall_inc = ~load & (|req_act);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_sum[CNTW] ? '1 : gnt_sum[CNTW-1:0];
      if (stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stat_gnt_cnt   = gnt_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
